simd_addsub_pipe: RTL and testbench
===================================

// Module: simd_addsub_pipe
// PURPOSE
//   Parametrised successor to the single-lane SIMD adder. Performs lane-wise add or subtract
//   on SIMD_WIDTH packed elements of EW bits through a LAT-stage pipeline.
//   Per-lane overflow flags are produced. Valid/ready handshakes with full backpressure sit
//   on both sides. It is the arithmetic slot of the HW-ISA vector datapath, between the
//   operand fetch and writeback.
// PARAMETERS
//   SIMD_WIDTH  4   number of lanes
//   EW          8   element width in bits (>=2)
//   LAT         2   pipeline depth in cycles, legal range 1..4
//   SIGNED      1   1: two's-complement lanes; 0: unsigned lanes
// PORTS
//   clk    in   1               clock, rising edge
//   rst    in   1               asynchronous, active-high reset
//   en     in   1               block enable; 0 blocks new accepts, in-flight data drains
//   din    in   2*SIMD_WIDTH*EW operands {B,A}; lane i of A = din[i*EW +: EW], B in upper half
//   op     in   1               0 = A+B, 1 = A-B; sampled with din
//   dvld   in   1               input beat valid
//   rdy    out  1               input ready; transfer when dvld & rdy
//   dout   out  SIMD_WIDTH*EW   lane results, lane i = dout[i*EW +: EW]
//   ovf    out  SIMD_WIDTH      per-lane overflow (signed) / carry-borrow (unsigned)
//   ovld   out  1               output beat valid
//   ordy   in   1               downstream ready; output transfer when ovld & ordy
// BEHAVIOUR
//   - Reset (async assert, sync release on clk): all stage valids=0; dout=0, ovf=0, ovld=0,
//     rdy=0 while rst is high.
//   - Pipeline: LAT register stages, each with a valid bit. Stage k advances when stage k+1
//     is empty or advancing. The last stage advances when !ovld | ordy.
//   - rdy = en & (stage0 empty | stage0 advancing). rdy is combinational from ordy (no skid).
//     Bubbles collapse.
//   - Latency: an accepted beat appears on ovld exactly LAT cycles later if ordy stays high.
//     Throughput is 1 beat/cycle.
//   - Stall: while ovld & !ordy, dout/ovf/ovld are held bit-stable. Upstream stages fill,
//     then rdy drops.
//   - Arithmetic: computed in stage 0 at EW+1 bits. op/din are captured together; op never
//     affects an in-flight beat.
//     - Wrap result = low EW bits (mod 2^EW).
//     - SIGNED=1: ovf = sign(A) == sign(B') and sign(result) != sign(A), where B' = B or -B.
//     - SIGNED=0: ovf = carry-out for add, borrow for sub.
//   - Later stages only delay; LAT=1 means the registered output stage only.
//   - en deassert mid-stream: the current accept completes; rdy=0 from the next evaluation.
//     Valid beats keep flowing out.
//   - Simultaneous accept and emit with the pipe full: legal, occupancy unchanged.
//   - dvld without rdy: no state change. The source must hold din/op (standard valid/ready).
//   - Boundary values (SIGNED=1, EW=8): 0x7F+0x01 -> 0x80 ovf=1; 0x80-0x01 -> 0x7F ovf=1.
// CONFIGURATION
//   SIMD_ADDSUB_SAT_EN defined: each lane with ovf=1 outputs the clamped value instead of
//   the wrap value.
//     - SIGNED=1: clamps to 2^(EW-1)-1 or -2^(EW-1).
//     - SIGNED=0: clamps to 2^EW-1 (add) or 0 (sub).
//     - ovf still reports the saturation event.
//   Not defined: wrap only; no clamp logic is synthesised.
// STRUCTURE
//   simd_pkg: localparams OP_ADD=1'b0, OP_SUB=1'b1; lane-slice helper function
//   lane_sel(vec,i,EW).
//   Sub-module simd_lane_addsub: one combinational lane (A, B, op -> res, ovf, sat mux).
//   Instantiated SIMD_WIDTH times in a generate loop.
//   Top level holds the valid/data stage registers and the handshake logic.
// TESTING (SIMD_WIDTH=4, EW=8, LAT=2, SIGNED=1)
//   1. A=0x04030201, B=0x01010101, op=0 with ordy=1 -> 2 cycles later dout=0x05040302,
//      ovf=0, ovld pulse 1 cycle.
//   2. A=lanes{7F,80,00,FF}, B=lanes{01,01,01,01}, op=1 -> wrap {7E,7F,FF,FE}, ovf={0,1,0,0}.
//      With SAT_EN, lane1 = 0x80.
//   3. Stream 8 beats with ordy=0 for cycles 3..6 -> dout held stable, rdy low once the pipe
//      is full. All 8 beats emerge in order, none lost or duplicated.
//   4. A=7F, B=01, op=0 -> wrap 0x80 ovf=1; with SAT_EN 0x7F ovf=1. SIGNED=0: FF+01 -> 0x00
//      carry=1; with SAT_EN 0xFF.
//   5. Assert rst with 2 beats in flight -> ovld/dout/ovf = 0 immediately (async). After
//      release, the first new beat has latency 2.
//   6. en=0 with dvld=1 -> rdy=0, no accept. In-flight beats still drain. With en=1, the next
//      accept occurs the same cycle.

Source files
------------

// File: rtl/simd_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
//   Shared definitions for the SIMD add/subtract datapath.
//   - OP_ADD / OP_SUB : encodings of the 1-bit op input.
//   - lane_sel        : extracts element i of width ew from a packed vector.
//                       The vector argument is LANE_VEC_MAX bits wide and the
//                       returned element is LANE_MAX bits wide. Callers
//                       zero-extend their vector and cast the result down to
//                       their element width.
// -----------------------------------------------------------------------------
package simd_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Widest packed operand vector and widest element that lane_sel handles.
   localparam int LANE_VEC_MAX = 1024;
   localparam int LANE_MAX     = 64;

   function automatic logic [LANE_MAX-1:0] lane_sel(
      input logic [LANE_VEC_MAX-1:0] vec,
      input int                      i,
      input int                      ew
   );
      logic [LANE_VEC_MAX-1:0] shifted;
      logic [LANE_MAX-1:0]     mask;
      shifted = vec >> (i * ew);
      mask    = (ew >= LANE_MAX) ? '1 : ((LANE_MAX'(1) << ew) - LANE_MAX'(1));
      return shifted[LANE_MAX-1:0] & mask;
   endfunction

endpackage

// File: rtl/simd_lane_addsub.sv
// -----------------------------------------------------------------------------
// simd_lane_addsub
//   One combinational SIMD lane. It computes a+b or a-b at EW+1 bits and
//   returns the EW-bit result and an overflow flag.
//   Optional macro SIMD_ADDSUB_SAT_EN: an overflowing lane returns the clamped
//   value instead of the wrapped value.
// Ports
//   a   in  EW  operand A
//   b   in  EW  operand B
//   op  in  1   OP_ADD (A+B) or OP_SUB (A-B)
//   res out EW  lane result (wrapped, or clamped when saturation is built in)
//   ovf out 1   signed overflow (SIGNED=1) or carry/borrow (SIGNED=0)
// -----------------------------------------------------------------------------
module simd_lane_addsub
   import simd_pkg::*;
#(
   parameter int EW     = 8,
   parameter bit SIGNED = 1'b1
) (
   input  logic [EW-1:0] a,
   input  logic [EW-1:0] b,
   input  logic          op,
   output logic [EW-1:0] res,
   output logic          ovf
);

   // The operands are extended by one bit: sign-extended for signed lanes and
   // zero-extended for unsigned lanes. This makes full[] the exact
   // mathematical result.
   logic          ext_a;
   logic          ext_b;
   logic [EW:0]   full;
   logic          lane_ovf;

   assign ext_a = SIGNED & a[EW-1];
   assign ext_b = SIGNED & b[EW-1];

   always_comb begin
      case (op)
         OP_ADD:  full = {ext_a, a} + {ext_b, b};
         OP_SUB:  full = {ext_a, a} - {ext_b, b};
         default: full = '0;
      endcase
   end

   // Signed case: the exact result does not fit in EW bits when the top two
   // bits differ. Unsigned case: the top bit is the carry or the borrow.
   assign lane_ovf = SIGNED ? (full[EW] ^ full[EW-1]) : full[EW];
   assign ovf      = lane_ovf;

`ifdef SIMD_ADDSUB_SAT_EN
   logic [EW-1:0] clamp;

   // Signed case: full[EW] is the true sign, so it picks the clamp direction.
   // Unsigned case: an add can only overflow upward and a sub only downward.
   always_comb begin
      if (SIGNED)
         clamp = full[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
      else
         clamp = (op == OP_SUB) ? '0 : '1;
   end

   assign res = lane_ovf ? clamp : full[EW-1:0];
`else
   assign res = full[EW-1:0];
`endif

endmodule

// File: rtl/simd_addsub_pipe.sv
// -----------------------------------------------------------------------------
// simd_addsub_pipe
//   Lane-wise add/subtract on SIMD_WIDTH elements of EW bits each, through a
//   pipeline of LAT stages (LAT = 1..4). Both sides use valid/ready handshakes
//   with full backpressure.
//   The arithmetic is done in front of stage 0. Later stages only delay the
//   data. The last stage drives the outputs.
//   Optional macro SIMD_ADDSUB_SAT_EN: overflowing lanes saturate instead of
//   wrapping.
//   2*SIMD_WIDTH*EW must not exceed simd_pkg::LANE_VEC_MAX.
// Ports
//   clk   in  1              rising-edge clock
//   rst   in  1              asynchronous active-high reset; deassert it
//                            synchronously to clk
//   en    in  1              block enable; 0 stops accepts and lets the pipe drain
//   din   in  2*SIMD_WIDTH*EW {B,A}; A lane i = din[i*EW +: EW], B in upper half
//   op    in  1              0: A+B, 1: A-B; captured with din
//   dvld  in  1              input beat valid
//   rdy   out 1              input ready (combinational from ordy)
//   dout  out SIMD_WIDTH*EW  lane results
//   ovf   out SIMD_WIDTH     per-lane overflow / carry-borrow
//   ovld  out 1              output beat valid
//   ordy  in  1              downstream ready
// -----------------------------------------------------------------------------
module simd_addsub_pipe
   import simd_pkg::*;
#(
   parameter int SIMD_WIDTH = 4,
   parameter int EW         = 8,
   parameter int LAT        = 2,
   parameter bit SIGNED     = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [2*SIMD_WIDTH*EW-1:0] din,
   input  logic                      op,
   input  logic                      dvld,
   output logic                      rdy,
   output logic [SIMD_WIDTH*EW-1:0]  dout,
   output logic [SIMD_WIDTH-1:0]     ovf,
   output logic                      ovld,
   input  logic                      ordy
);

   localparam int DW = SIMD_WIDTH * EW;

   logic [LANE_VEC_MAX-1:0] din_ext;
   logic [DW-1:0]           res_comb;
   logic [SIMD_WIDTH-1:0]   ovf_comb;

   logic [DW-1:0]           data_reg [LAT];
   logic [SIMD_WIDTH-1:0]   ovf_reg  [LAT];
   logic [LAT-1:0]          vld_reg;
   logic [LAT-1:0]          open;
   logic                    accept;

   assign din_ext = LANE_VEC_MAX'(din);

   // ---------------------------------------------------------------- lanes
   genvar gi;
   generate
      for (gi = 0; gi < SIMD_WIDTH; gi++) begin : g_lane
         logic [EW-1:0] a_lane;
         logic [EW-1:0] b_lane;

         assign a_lane = EW'(lane_sel(din_ext, gi, EW));
         assign b_lane = EW'(lane_sel(din_ext, gi + SIMD_WIDTH, EW));

         simd_lane_addsub #(
            .EW     (EW),
            .SIGNED (SIGNED)
         ) u_lane (
            .a   (a_lane),
            .b   (b_lane),
            .op  (op),
            .res (res_comb[gi*EW +: EW]),
            .ovf (ovf_comb[gi])
         );
      end

      // Stage k can take a beat unless it and every stage after it are full
      // while the output is stalled. This closed form gives the same answer
      // as the ripple "next stage empty or advancing" rule, so an empty stage
      // (a bubble) is always filled.
      for (gi = 0; gi < LAT; gi++) begin : g_open
         assign open[gi] = ordy || !(&vld_reg[LAT-1:gi]);
      end
   endgenerate

   // ------------------------------------------------------------ handshake
   assign rdy    = en && open[0] && !rst;
   assign accept = dvld && rdy;

   // ------------------------------------------------------------- pipeline
   // A stage loads its data only when a valid beat moves into it. A stage
   // that drains therefore keeps its old payload while its valid bit is 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_reg <= '0;
         for (int k = 0; k < LAT; k++) begin
            data_reg[k] <= '0;
            ovf_reg[k]  <= '0;
         end
      end else begin
         if (open[0]) begin
            vld_reg[0] <= accept;
            if (accept) begin
               data_reg[0] <= res_comb;
               ovf_reg[0]  <= ovf_comb;
            end
         end
         for (int k = 1; k < LAT; k++) begin
            if (open[k]) begin
               vld_reg[k] <= vld_reg[k-1];
               if (vld_reg[k-1]) begin
                  data_reg[k] <= data_reg[k-1];
                  ovf_reg[k]  <= ovf_reg[k-1];
               end
            end
         end
      end
   end

   assign dout = data_reg[LAT-1];
   assign ovf  = ovf_reg[LAT-1];
   assign ovld = vld_reg[LAT-1];

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_simd_addsub_pipe
//   Self-checking bench for simd_addsub_pipe (SIMD_WIDTH=4, EW=8, LAT=2,
//   SIGNED=1). Expected lane results come from integer arithmetic on the
//   operand values. Expected handshake behaviour comes from an occupancy count
//   and a FIFO of expected beats. Expectations follow SIMD_ADDSUB_SAT_EN when
//   it is defined.
// -----------------------------------------------------------------------------
module tb_simd_addsub_pipe;

   localparam int N      = 4;
   localparam int EW     = 8;
   localparam int LAT    = 2;
   localparam bit SIGNED = 1'b1;
   localparam int DW     = N * EW;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [2*DW-1:0] din;
   logic            op;
   logic            dvld;
   logic            rdy;
   logic [DW-1:0]   dout;
   logic [N-1:0]    ovf;
   logic            ovld;
   logic            ordy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   simd_addsub_pipe #(
      .SIMD_WIDTH (N),
      .EW         (EW),
      .LAT        (LAT),
      .SIGNED     (SIGNED)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .din  (din),
      .op   (op),
      .dvld (dvld),
      .rdy  (rdy),
      .dout (dout),
      .ovf  (ovf),
      .ovld (ovld),
      .ordy (ordy)
   );

   // Reference: the true integer result of each lane, range-checked against
   // the element type, then wrapped or clamped. Returns {ovf, dout}.
   function automatic logic [N+DW-1:0] model(input logic [2*DW-1:0] d, input logic o);
      logic [DW-1:0] r;
      logic [N-1:0]  v;
      logic [EW-1:0] au, bu;
      int a, b, s, lo, hi;
      for (int i = 0; i < N; i++) begin
         au = d[i*EW +: EW];
         bu = d[DW + i*EW +: EW];
         if (SIGNED) begin
            a  = int'($signed(au));
            b  = int'($signed(bu));
            lo = -(1 << (EW-1));
            hi = (1 << (EW-1)) - 1;
         end else begin
            a  = int'(au);
            b  = int'(bu);
            lo = 0;
            hi = (1 << EW) - 1;
         end
         s    = o ? (a - b) : (a + b);
         v[i] = (s < lo) || (s > hi);
`ifdef SIMD_ADDSUB_SAT_EN
         if (s > hi) s = hi;
         else if (s < lo) s = lo;
`endif
         r[i*EW +: EW] = s[EW-1:0];
      end
      return {v, r};
   endfunction

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst = 1'b1; en = 1'b1; dvld = 1'b0; din = '0; op = 1'b0; ordy = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total_cnt++; if (ovld !== 1'b0) $display("FAIL reset_ovld: got %b want 0", ovld); else pass_cnt++;
      total_cnt++; if (dout !== '0) $display("FAIL reset_dout: got %h want 0", dout); else pass_cnt++;
      total_cnt++; if (ovf !== '0) $display("FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
      total_cnt++; if (rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", rdy); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total_cnt++; if (rdy !== 1'b1) $display("FAIL reset_release_rdy: got %b want 1", rdy); else pass_cnt++;
   endtask

   task automatic test_basic();
      @(negedge clk);
      din = {32'h01010101, 32'h04030201}; op = 1'b0; dvld = 1'b1; ordy = 1'b1;
      #1;
      total_cnt++; if (rdy !== 1'b1) $display("FAIL basic_rdy: got %b want 1", rdy); else pass_cnt++;
      @(negedge clk);
      dvld = 1'b0;
      #1;
      total_cnt++; if (ovld !== 1'b0) $display("FAIL basic_early_ovld: got %b want 0", ovld); else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++; if (ovld !== 1'b1) $display("FAIL basic_ovld: got %b want 1", ovld); else pass_cnt++;
      total_cnt++; if (dout !== 32'h05040302) $display("FAIL basic_dout: got %h want 05040302", dout); else pass_cnt++;
      total_cnt++; if (ovf !== 4'b0000) $display("FAIL basic_ovf: got %b want 0000", ovf); else pass_cnt++;
      $display("basic beat: dout=%h ovf=%b", dout, ovf);
      @(negedge clk);
      #1;
      total_cnt++; if (ovld !== 1'b0) $display("FAIL basic_ovld_pulse: got %b want 0", ovld); else pass_cnt++;
   endtask

   task automatic test_boundary();
      logic [2*DW-1:0] vin  [3];
      logic            vop  [3];
      logic [DW-1:0]   vexp [3];
      logic [N-1:0]    vovf [3];
      // lanes listed lane3..lane0 inside each word
      vin[0] = {32'h01010101, 32'hFF00807F}; vop[0] = 1'b1; vovf[0] = 4'b0010;
      vin[1] = {32'h80FF0101, 32'h8080807F}; vop[1] = 1'b0; vovf[1] = 4'b1101;
      vin[2] = {32'h80808080, 32'h807FFF00}; vop[2] = 1'b1; vovf[2] = 4'b0101;
`ifdef SIMD_ADDSUB_SAT_EN
      vexp[0] = 32'hFEFF807E;
      vexp[1] = 32'h8080817F;
      vexp[2] = 32'h007F7F7F;
`else
      vexp[0] = 32'hFEFF7F7E;
      vexp[1] = 32'h007F8180;
      vexp[2] = 32'h00FF7F80;
`endif
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         din = vin[t]; op = vop[t]; dvld = 1'b1; ordy = 1'b1;
         @(negedge clk);
         dvld = 1'b0;
         @(negedge clk);
         #1;
         total_cnt++; if (ovld !== 1'b1) $display("FAIL boundary%0d_ovld: got %b want 1", t, ovld); else pass_cnt++;
         total_cnt++; if (dout !== vexp[t]) $display("FAIL boundary%0d_dout: got %h want %h", t, dout, vexp[t]); else pass_cnt++;
         total_cnt++; if (ovf !== vovf[t]) $display("FAIL boundary%0d_ovf: got %b want %b", t, ovf, vovf[t]); else pass_cnt++;
         $display("boundary beat %0d: dout=%h ovf=%b", t, dout, ovf);
      end
      @(negedge clk);
   endtask

   // mode 0: continuous source, ordy low for cycles 3..6
   // mode 1: random dvld/ordy
   // mode 2: random dvld/ordy/en
   task automatic test_stream(input int nbeats, input int mode, input int maxcyc);
      logic [N+DW-1:0] exp_q[$];
      logic [N+DW-1:0] e;
      logic [2*DW-1:0] cur_din;
      logic            cur_op, pending, prev_stall, exp_rdy, acc, emit;
      logic [DW-1:0]   prev_dout;
      logic [N-1:0]    prev_ovf;
      int sent, got, occ;
      sent = 0; got = 0; occ = 0; pending = 1'b0; prev_stall = 1'b0;
      prev_dout = '0; prev_ovf = '0;
      cur_din = {$urandom, $urandom}; cur_op = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < maxcyc && got < nbeats; cyc++) begin
         @(negedge clk);
         case (mode)
            0:       begin en = 1'b1; ordy = !(cyc >= 3 && cyc <= 6); end
            1:       begin en = 1'b1; ordy = ($urandom_range(0, 3) != 0); end
            default: begin en = ($urandom_range(0, 2) != 0); ordy = ($urandom_range(0, 2) != 0); end
         endcase
         dvld = pending || ((sent < nbeats) && (mode == 0 || $urandom_range(0, 3) != 0));
         din = cur_din; op = cur_op;
         #1;
         exp_rdy = en && !(occ == LAT && !ordy);
         total_cnt++; if (rdy !== exp_rdy) $display("FAIL stream%0d_rdy cyc %0d: got %b want %b", mode, cyc, rdy, exp_rdy); else pass_cnt++;
         if (prev_stall) begin
            total_cnt++;
            if (ovld !== 1'b1 || dout !== prev_dout || ovf !== prev_ovf)
               $display("FAIL stream%0d_hold cyc %0d: got %b/%h/%b want 1/%h/%b", mode, cyc, ovld, dout, ovf, prev_dout, prev_ovf);
            else pass_cnt++;
         end
         acc  = dvld && rdy;
         emit = ovld && ordy;
         if (emit) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL stream%0d_spurious cyc %0d: got beat %h with none pending", mode, cyc, dout);
            end else begin
               e = exp_q.pop_front();
               if (dout !== e[DW-1:0] || ovf !== e[N+DW-1:DW])
                  $display("FAIL stream%0d_beat%0d: got %h/%b want %h/%b", mode, got, dout, ovf, e[DW-1:0], e[N+DW-1:DW]);
               else pass_cnt++;
            end
            $display("stream%0d beat %0d: dout=%h ovf=%b", mode, got, dout, ovf);
            got++;
         end
         if (acc) begin
            exp_q.push_back(model(din, op));
            sent++;
            cur_din = {$urandom, $urandom}; cur_op = 1'($urandom_range(0, 1));
            pending = 1'b0;
         end else begin
            pending = dvld;
         end
         occ = occ + (acc ? 1 : 0) - (emit ? 1 : 0);
         prev_stall = ovld && !ordy;
         prev_dout = dout; prev_ovf = ovf;
      end
      total_cnt++;
      if (got != nbeats || exp_q.size() != 0)
         $display("FAIL stream%0d_count: got %0d beats want %0d (%0d left)", mode, got, nbeats, exp_q.size());
      else pass_cnt++;
      dvld = 1'b0; en = 1'b1; ordy = 1'b1;
   endtask

   task automatic test_async_reset();
      logic [N+DW-1:0] e;
      @(negedge clk);
      din = {32'h01020304, 32'h11223344}; op = 1'b0; dvld = 1'b1; ordy = 1'b1;
      @(negedge clk);
      din = {32'h05050505, 32'h40302010}; op = 1'b1;
      @(negedge clk);
      dvld = 1'b0;
      #1;
      total_cnt++; if (ovld !== 1'b1) $display("FAIL arst_inflight_ovld: got %b want 1", ovld); else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      total_cnt++; if (ovld !== 1'b0) $display("FAIL arst_ovld: got %b want 0", ovld); else pass_cnt++;
      total_cnt++; if (dout !== '0) $display("FAIL arst_dout: got %h want 0", dout); else pass_cnt++;
      total_cnt++; if (ovf !== '0) $display("FAIL arst_ovf: got %b want 0", ovf); else pass_cnt++;
      total_cnt++; if (rdy !== 1'b0) $display("FAIL arst_rdy: got %b want 0", rdy); else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      din = {32'h7F7F0101, 32'h01017F7F}; op = 1'b0; dvld = 1'b1;
      e = model(din, op);
      #1;
      total_cnt++; if (rdy !== 1'b1) $display("FAIL arst_post_rdy: got %b want 1", rdy); else pass_cnt++;
      @(negedge clk);
      dvld = 1'b0;
      #1;
      total_cnt++; if (ovld !== 1'b0) $display("FAIL arst_post_early: got %b want 0", ovld); else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++;
      if (ovld !== 1'b1 || dout !== e[DW-1:0] || ovf !== e[N+DW-1:DW])
         $display("FAIL arst_post_beat: got %b/%h/%b want 1/%h/%b", ovld, dout, ovf, e[DW-1:0], e[N+DW-1:DW]);
      else pass_cnt++;
      $display("post-reset beat: dout=%h ovf=%b", dout, ovf);
      @(negedge clk);
   endtask

   task automatic test_enable();
      logic [N+DW-1:0] ex, ey;
      logic [2*DW-1:0] dx, dy;
      dx = {32'h10203040, 32'h01020304};
      dy = {32'h00000001, 32'h80000000};
      ex = model(dx, 1'b0);
      ey = model(dy, 1'b1);
      @(negedge clk);
      en = 1'b1; ordy = 1'b1; din = dx; op = 1'b0; dvld = 1'b1;
      #1;
      total_cnt++; if (rdy !== 1'b1) $display("FAIL en_first_rdy: got %b want 1", rdy); else pass_cnt++;
      @(negedge clk);
      en = 1'b0; din = dy; op = 1'b1;
      #1;
      total_cnt++; if (rdy !== 1'b0) $display("FAIL en_off_rdy: got %b want 0", rdy); else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++; if (rdy !== 1'b0) $display("FAIL en_off_rdy2: got %b want 0", rdy); else pass_cnt++;
      total_cnt++;
      if (ovld !== 1'b1 || dout !== ex[DW-1:0] || ovf !== ex[N+DW-1:DW])
         $display("FAIL en_drain_beat: got %b/%h/%b want 1/%h/%b", ovld, dout, ovf, ex[DW-1:0], ex[N+DW-1:DW]);
      else pass_cnt++;
      $display("enable drain beat: dout=%h ovf=%b", dout, ovf);
      @(negedge clk);
      en = 1'b1;
      #1;
      total_cnt++; if (rdy !== 1'b1) $display("FAIL en_on_rdy: got %b want 1", rdy); else pass_cnt++;
      total_cnt++; if (ovld !== 1'b0) $display("FAIL en_no_dup: got %b want 0", ovld); else pass_cnt++;
      @(negedge clk);
      dvld = 1'b0;
      @(negedge clk);
      #1;
      total_cnt++;
      if (ovld !== 1'b1 || dout !== ey[DW-1:0] || ovf !== ey[N+DW-1:DW])
         $display("FAIL en_resume_beat: got %b/%h/%b want 1/%h/%b", ovld, dout, ovf, ey[DW-1:0], ey[N+DW-1:DW]);
      else pass_cnt++;
      $display("enable resume beat: dout=%h ovf=%b", dout, ovf);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_stream(8, 0, 40);
      test_enable();
      test_async_reset();
      test_stream(40, 1, 400);
      test_stream(40, 2, 400);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog");
   end

endmodule
